scaler_h_ctrl: RTL

Frame-synchronous configuration controller for the horizontal scaler. Software writes input and output line widths. The block converts them to a (4.12) scale step with a sequential restoring divider and holds the result as a pending value. It commits that value to the scaler's `scale_step` input only at the start of an active frame, so a step never changes mid-frame. Sits between the register bank and `scaler_h`, and snoops the same `de`/`hs`/`vs` stream that feeds the scaler.

---
 rtl/scaler_h_ctrl_pkg.sv | 19 +
 rtl/scaler_h_ctrl_div.sv | 62 ++++++
 rtl/scaler_h_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/scaler_h_ctrl_pkg.sv
// Shared types and constants for the horizontal scaler configuration controller.
package scaler_h_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    CHECK = 2'd2,
    ARMED = 2'd3
  } ctrl_state_e;

  localparam int ERR_INVALID = 0;
  localparam int ERR_LATE    = 1;
  localparam int ERR_DROP    = 2;

  function automatic int calc_frac(input int pixel_step);
    return $clog2(pixel_step);
  endfunction

endpackage

// File: rtl/scaler_h_ctrl_div.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// start loads the operands; done is high in the cycle whose edge produces the last bit.
module scaler_h_ctrl_div
  import scaler_h_ctrl_pkg::*;
#(
  parameter int DVD_W = 25,
  parameter int DVS_W = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DVD_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DVD_W - 1);

  logic [DVS_W-1:0] rem;
  logic [DVS_W-1:0] dvs;
  logic [DVD_W-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic [DVS_W:0]   trial;
  logic [DVS_W-1:0] diff;
  logic             take;

  // The remainder stays below the divisor, so the low DVS_W bits of the
  // subtraction are exact whenever the subtraction is taken.
  always_comb begin
    trial = {rem, shreg[DVD_W-1]};
    take  = (trial >= {1'b0, dvs});
    diff  = trial[DVS_W-1:0] - dvs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      dvs   <= '0;
      shreg <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      rem   <= '0;
      dvs   <= divisor;
      shreg <= dividend;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      shreg <= {shreg[DVD_W-2:0], take};
      rem   <= take ? diff : trial[DVS_W-1:0];
      cnt   <= cnt + 1'b1;
      if (cnt == LAST) busy <= 1'b0;
    end
  end

  assign done     = busy && (cnt == LAST);
  assign quotient = shreg;

endmodule

// File: rtl/scaler_h_ctrl.sv
// Frame-synchronous scale-step controller: divides in_w*PIXEL_STEP by out_w and commits at vs fall.
// Optional line-width measurement is built when SCALER_H_CTRL_MEASURE_EN is defined.
module scaler_h_ctrl
  import scaler_h_ctrl_pkg::*;
#(
  parameter int PIXEL_STEP    = 4096,
  parameter int STEP_WIDTH    = 16,
  parameter int LINE_SIZE_MAX = 4096,
  parameter int W_WIDTH       = $clog2(LINE_SIZE_MAX) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [W_WIDTH-1:0]    cfg_in_w_i,
  input  logic [W_WIDTH-1:0]    cfg_out_w_i,
  input  logic                  cfg_wr_i,
  output logic                  cfg_busy_o,
  input  logic                  vs_i,
  input  logic                  hs_i,
  input  logic                  de_i,
  output logic [STEP_WIDTH-1:0] scale_step_o,
  output logic                  bypass_o,
  output logic                  commit_o,
  output logic [2:0]            err_o,
`ifdef SCALER_H_CTRL_MEASURE_EN
  output logic [W_WIDTH-1:0]    meas_w_o,
`endif
  output ctrl_state_e           dbg_state
);

  localparam int FRAC  = calc_frac(PIXEL_STEP);
  localparam int DVD_W = W_WIDTH + FRAC;
  localparam logic [STEP_WIDTH-1:0] UNITY = STEP_WIDTH'(PIXEL_STEP);

  ctrl_state_e            state;
  logic                   vs_d;
  logic                   frame_start;
  logic [W_WIDTH-1:0]     in_w_q;
  logic [W_WIDTH-1:0]     out_w_q;
  logic [STEP_WIDTH-1:0]  pend_step;
  logic                   pend_bypass;
  logic                   wr_idle;
  logic                   wr_invalid;
  logic                   div_start;
  logic                   div_busy;
  logic                   div_done;
  logic [DVD_W-1:0]       div_quot;
  logic                   quot_sat;
  logic                   meas_mismatch;

  // Falling edge of vs, judged against the previous cycle's sampled value.
  assign frame_start = vs_d && !vs_i;
  assign wr_idle     = (state == IDLE) || (state == ARMED);
  assign wr_invalid  = (cfg_out_w_i == '0);
  assign div_start   = cfg_wr_i && wr_idle && !wr_invalid;
  assign quot_sat    = |div_quot[DVD_W-1:STEP_WIDTH];
  assign cfg_busy_o  = div_busy || (state == CHECK);
  assign dbg_state   = state;

  scaler_h_ctrl_div #(
    .DVD_W (DVD_W),
    .DVS_W (W_WIDTH)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend ({cfg_in_w_i, {FRAC{1'b0}}}),
    .divisor  (cfg_out_w_i),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

`ifdef SCALER_H_CTRL_MEASURE_EN
  logic               hs_d;
  logic               hs_rise;
  logic               vs_rise;
  logic [W_WIDTH-1:0] pix_cnt;
  logic [W_WIDTH-1:0] last_line;
  logic [W_WIDTH-1:0] line_now;
  logic [W_WIDTH-1:0] pend_in_w;
  logic [W_WIDTH-1:0] committed_in_w;

  assign hs_rise  = hs_i && !hs_d;
  assign vs_rise  = vs_i && !vs_d;
  assign line_now = hs_rise ? pix_cnt : last_line;
  // A zero committed width means nothing has been committed since reset.
  assign meas_mismatch = vs_rise && (committed_in_w != '0) && (line_now != committed_in_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_d      <= 1'b1;
      pix_cnt   <= '0;
      last_line <= '0;
      meas_w_o  <= '0;
    end else begin
      hs_d <= hs_i;
      if (hs_rise) begin
        last_line <= pix_cnt;
        pix_cnt   <= '0;
      end else if (!hs_i && de_i) begin
        pix_cnt <= pix_cnt + 1'b1;
      end
      if (vs_rise) meas_w_o <= line_now;
    end
  end
`else
  logic unused_stream;
  assign unused_stream = &{1'b0, hs_i, de_i};
  assign meas_mismatch = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      vs_d         <= 1'b1;
      in_w_q       <= '0;
      out_w_q      <= '0;
      pend_step    <= UNITY;
      pend_bypass  <= 1'b1;
      scale_step_o <= UNITY;
      bypass_o     <= 1'b1;
      commit_o     <= 1'b0;
      err_o        <= '0;
`ifdef SCALER_H_CTRL_MEASURE_EN
      pend_in_w      <= '0;
      committed_in_w <= '0;
`endif
    end else begin
      vs_d     <= vs_i;
      commit_o <= 1'b0;
      case (state)
        IDLE, ARMED: begin
          // A commit and a write in the same cycle: the old pending value
          // lands first, then the write starts a fresh divide.
          if (frame_start && (state == ARMED)) begin
            scale_step_o <= pend_step;
            bypass_o     <= pend_bypass;
            commit_o     <= 1'b1;
            state        <= IDLE;
`ifdef SCALER_H_CTRL_MEASURE_EN
            committed_in_w <= pend_in_w;
`endif
          end
          if (cfg_wr_i) begin
            in_w_q  <= cfg_in_w_i;
            out_w_q <= cfg_out_w_i;
            err_o   <= '0;
            if (wr_invalid) err_o[ERR_INVALID] <= 1'b1;
            else            state <= DIV;
          end
        end
        DIV: begin
          if (div_done) state <= CHECK;
        end
        CHECK: begin
          if (quot_sat) begin
            pend_step          <= '1;
            err_o[ERR_INVALID] <= 1'b1;
          end else begin
            pend_step <= div_quot[STEP_WIDTH-1:0];
          end
          pend_bypass <= (in_w_q == out_w_q);
`ifdef SCALER_H_CTRL_MEASURE_EN
          pend_in_w <= in_w_q;
`endif
          state <= ARMED;
        end
        default: state <= IDLE;
      endcase
      if (cfg_busy_o && cfg_wr_i)    err_o[ERR_DROP] <= 1'b1;
      if (cfg_busy_o && frame_start) err_o[ERR_LATE] <= 1'b1;
      if (meas_mismatch)             err_o[ERR_DROP] <= 1'b1;
    end
  end

endmodule
